// File: rtl/channel_combiner.sv
// Aligns the R/G/B dot products in per-channel FIFOs, then sums them with a bias, applies ReLU and requantizes to one pixel.
// Optional build macro ROUND_NEAREST_EN adds round-half-up before the requantizing shift.
module channel_combiner #(
   parameter int inWidth   = 32,
   parameter int outWidth  = 8,
   parameter int fifoDepth = 4,
   parameter int shift     = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [inWidth-1:0]  R_dotproduct,
   input  logic                R_ready,
   input  logic [inWidth-1:0]  G_dotproduct,
   input  logic                G_ready,
   input  logic [inWidth-1:0]  B_dotproduct,
   input  logic                B_ready,
   input  logic [inWidth-1:0]  bias,
   output logic [outWidth-1:0] pixel_out,
   output logic                pixel_valid,
   input  logic                pixel_accept,
   output logic                overflow,
   output logic [15:0]         pixel_count
);

   localparam int AW    = $clog2(fifoDepth);
   localparam int SUM_W = inWidth + 2;
   localparam logic [SUM_W-1:0] MAXV = {{(SUM_W-outWidth){1'b0}}, {outWidth{1'b1}}};
`ifdef ROUND_NEAREST_EN
   localparam logic [SUM_W-1:0] RND = SUM_W'(1) << (shift - 1);
`endif

   function automatic logic [SUM_W-1:0] relu_shift(input logic signed [SUM_W-1:0] s);
      logic [SUM_W-1:0] m;
      m = s[SUM_W-1] ? '0 : $unsigned(s);
`ifdef ROUND_NEAREST_EN
      m = m + RND;
`endif
      return m >> shift;
   endfunction

   function automatic logic [outWidth-1:0] saturate(input logic [SUM_W-1:0] v);
      return (v > MAXV) ? '1 : v[outWidth-1:0];
   endfunction

   logic [inWidth-1:0]      din [3];
   logic                    rdy [3];
   logic [inWidth-1:0]      mem [3][fifoDepth];
   logic [AW:0]             wr_ptr [3];
   logic [AW:0]             rd_ptr [3];
   logic [inWidth-1:0]      head [3];
   logic                    empty [3];
   logic                    full [3];
   logic                    wr_en [3];
   logic                    pop, ld_p1, ld_p2;
   logic                    vld_p1, vld_p2;
   logic signed [SUM_W-1:0] sum_p1;

   assign din[0] = R_dotproduct;
   assign din[1] = G_dotproduct;
   assign din[2] = B_dotproduct;
   assign rdy[0] = R_ready;
   assign rdy[1] = G_ready;
   assign rdy[2] = B_ready;

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         head[c]  = mem[c][rd_ptr[c][AW-1:0]];
         empty[c] = (wr_ptr[c] == rd_ptr[c]);
         full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                    (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
      end
   end

   // A full stage can still load if everything downstream moves this edge.
   assign ld_p2 = ~vld_p2 | pixel_accept;
   assign ld_p1 = ~vld_p1 | ld_p2;
   assign pop   = ~empty[0] & ~empty[1] & ~empty[2] & ld_p1;

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         wr_en[c] = rdy[c] & (~full[c] | pop);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int c = 0; c < 3; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         overflow    <= 1'b0;
         pixel_count <= '0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
            if (pop)      rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
            if (rdy[c] && !wr_en[c]) overflow <= 1'b1;
         end
         if (ld_p1) vld_p1 <= pop;
         if (ld_p2) vld_p2 <= vld_p1;
         if (vld_p2 && pixel_accept) pixel_count <= pixel_count + 16'd1;
      end
   end

   assign pixel_valid = vld_p2;

   always_ff @(posedge clock) begin
      for (int c = 0; c < 3; c++) begin
         if (wr_en[c]) mem[c][wr_ptr[c][AW-1:0]] <= din[c];
      end
      // Stage 1: aligned triple plus bias, two guard bits so nothing wraps.
      if (ld_p1 && pop) begin
         sum_p1 <= $signed({{2{head[0][inWidth-1]}}, head[0]}) +
                   $signed({{2{head[1][inWidth-1]}}, head[1]}) +
                   $signed({{2{head[2][inWidth-1]}}, head[2]}) +
                   $signed({{2{bias[inWidth-1]}}, bias});
      end
   end

   // Stage 2: ReLU, requantize, saturate.
   always_ff @(posedge clock) begin
      if (reset) begin
         pixel_out <= '0;
      end else if (ld_p2 && vld_p1) begin
         pixel_out <= saturate(relu_shift(sum_p1));
      end
   end

endmodule

// File: tb/tb_channel_combiner.sv
// Directed bench for channel_combiner: alignment, ReLU, saturation, skew, backpressure, reset and rounding.
module tb_channel_combiner;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] R_dotproduct, G_dotproduct, B_dotproduct, bias;
   logic        R_ready, G_ready, B_ready;
   logic [7:0]  pixel_out;
   logic        pixel_valid;
   logic        pixel_accept;
   logic        overflow;
   logic [15:0] pixel_count;

   int checks   = 0;
   int failures = 0;

   channel_combiner dut (
      .clock        (clock),
      .reset        (reset),
      .R_dotproduct (R_dotproduct),
      .R_ready      (R_ready),
      .G_dotproduct (G_dotproduct),
      .G_ready      (G_ready),
      .B_dotproduct (B_dotproduct),
      .B_ready      (B_ready),
      .bias         (bias),
      .pixel_out    (pixel_out),
      .pixel_valid  (pixel_valid),
      .pixel_accept (pixel_accept),
      .overflow     (overflow),
      .pixel_count  (pixel_count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      R_ready = 1'b0; G_ready = 1'b0; B_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic send(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
      R_dotproduct = r; G_dotproduct = g; B_dotproduct = b;
      R_ready = 1'b1; G_ready = 1'b1; B_ready = 1'b1;
      step();
      R_ready = 1'b0; G_ready = 1'b0; B_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (pixel_out !== 8'd0) begin failures++; $display("FAIL reset_pixel_out got=%0d exp=0", pixel_out); end
      checks++;
      if (pixel_valid !== 1'b0) begin failures++; $display("FAIL reset_pixel_valid got=%b exp=0", pixel_valid); end
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++;
      if (pixel_count !== 16'd0) begin failures++; $display("FAIL reset_pixel_count got=%0d exp=0", pixel_count); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      bias = 32'd0; pixel_accept = 1'b1;
      send(32'd256, 32'd512, 32'd768);
      step();
      checks++;
      if (pixel_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", pixel_valid); end
      step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_out !== 8'd6) begin
         failures++; $display("FAIL single_pixel got=%b/%0d exp=1/6", pixel_valid, pixel_out);
      end
      step();
      checks++;
      if (pixel_count !== 16'd1 || pixel_valid !== 1'b0) begin
         failures++; $display("FAIL single_count got=%0d/%b exp=1/0", pixel_count, pixel_valid);
      end
   endtask

   task automatic test_relu();
      logic [7:0] exp_b;
      do_reset();
      pixel_accept = 1'b1;
      bias = 32'd0;
      send(-32'sd1000, 32'd100, 32'd100);
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_out !== 8'd0) begin
         failures++; $display("FAIL relu_negative got=%b/%0d exp=1/0", pixel_valid, pixel_out);
      end
      step();
      bias = 32'd2000;
`ifdef ROUND_NEAREST_EN
      exp_b = 8'd5;
`else
      exp_b = 8'd4;
`endif
      send(-32'sd1000, 32'd100, 32'd100);
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_out !== exp_b) begin
         failures++; $display("FAIL relu_bias got=%b/%0d exp=1/%0d", pixel_valid, pixel_out, exp_b);
      end
      step();
      bias = 32'd0;
   endtask

   task automatic test_saturation();
      do_reset();
      pixel_accept = 1'b1;
      bias = 32'd0;
      send(32'd40000, 32'd40000, 32'd40000);
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_out !== 8'd255) begin
         failures++; $display("FAIL sat_120000 got=%b/%0d exp=1/255", pixel_valid, pixel_out);
      end
      step();
      bias = 32'h7FFF_FFFF;
      send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_out !== 8'd255) begin
         failures++; $display("FAIL sat_max_nowrap got=%b/%0d exp=1/255", pixel_valid, pixel_out);
      end
      step();
      bias = 32'h8000_0000;
      send(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_out !== 8'd0) begin
         failures++; $display("FAIL sat_min_nowrap got=%b/%0d exp=1/0", pixel_valid, pixel_out);
      end
      step();
      bias = 32'd0;
   endtask

   task automatic test_skew();
      logic exp_v;
      do_reset();
      pixel_accept = 1'b1;
      bias = 32'd0;
      R_dotproduct = 32'd256; G_dotproduct = 32'd256; B_dotproduct = 32'd256;
      for (int c = 0; c <= 7; c++) begin
         R_ready = (c == 0);
         G_ready = (c == 3);
         B_ready = (c == 5);
         step();
         R_ready = 1'b0; G_ready = 1'b0; B_ready = 1'b0;
         exp_v = (c == 7);
         checks++;
         if (pixel_valid !== exp_v) begin
            failures++; $display("FAIL skew_valid edge=%0d got=%b exp=%b", c, pixel_valid, exp_v);
         end
      end
      checks++;
      if (pixel_out !== 8'd3) begin failures++; $display("FAIL skew_pixel got=%0d exp=3", pixel_out); end
      step();
   endtask

   task automatic test_back_to_back();
      logic       exp_v;
      logic [7:0] exp_p;
      do_reset();
      pixel_accept = 1'b1;
      bias = 32'd0;
      for (int c = 0; c <= 7; c++) begin
         if (c < 4) begin
            R_dotproduct = 32'(c + 1) << 8; G_dotproduct = 32'd0; B_dotproduct = 32'd0;
            R_ready = 1'b1; G_ready = 1'b1; B_ready = 1'b1;
         end
         step();
         R_ready = 1'b0; G_ready = 1'b0; B_ready = 1'b0;
         exp_v = (c >= 2 && c <= 5);
         exp_p = 8'(c - 1);
         checks++;
         if (pixel_valid !== exp_v || (exp_v && pixel_out !== exp_p)) begin
            failures++;
            $display("FAIL b2b edge=%0d got=%b/%0d exp=%b/%0d", c, pixel_valid, pixel_out, exp_v, exp_p);
         end
      end
      checks++;
      if (pixel_count !== 16'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", pixel_count); end
   endtask

   task automatic test_backpressure();
      int         n;
      logic [7:0] exp_p;
      do_reset();
      pixel_accept = 1'b0;
      bias = 32'd0;
      for (int k = 1; k <= 7; k++) begin
         R_dotproduct = 32'(k) << 8; G_dotproduct = 32'd0; B_dotproduct = 32'd0;
         R_ready = 1'b1; G_ready = 1'b1; B_ready = 1'b1;
         step();
         if (k == 6) begin
            checks++;
            if (overflow !== 1'b0) begin failures++; $display("FAIL bp_overflow_early got=%b exp=0", overflow); end
         end
      end
      R_ready = 1'b0; G_ready = 1'b0; B_ready = 1'b0;
      checks++;
      if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_out !== 8'd1) begin
         failures++; $display("FAIL bp_hold got=%b/%0d exp=1/1", pixel_valid, pixel_out);
      end
      pixel_accept = 1'b1;
      n = 0;
      exp_p = 8'd1;
      for (int i = 0; i < 20; i++) begin
         if (pixel_valid) begin
            checks++;
            if (pixel_out !== exp_p) begin
               failures++; $display("FAIL bp_drain idx=%0d got=%0d exp=%0d", n, pixel_out, exp_p);
            end
            exp_p++;
            n++;
         end
         step();
      end
      checks++;
      if (n != 6) begin failures++; $display("FAIL bp_drain_count got=%0d exp=6", n); end
      checks++;
      if (pixel_count !== 16'd6) begin failures++; $display("FAIL bp_pixel_count got=%0d exp=6", pixel_count); end
      checks++;
      if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_reset_mid();
      int stale;
      do_reset();
      pixel_accept = 1'b1;
      bias = 32'd0;
      send(32'd512, 32'd0, 32'd0);
      step(); step(); step();
      pixel_accept = 1'b0;
      for (int k = 1; k <= 7; k++) send(32'd768, 32'd0, 32'd0);
      reset = 1'b1;
      R_dotproduct = 32'd1024; R_ready = 1'b1; G_ready = 1'b1; B_ready = 1'b1;
      step();
      reset = 1'b0;
      R_ready = 1'b0; G_ready = 1'b0; B_ready = 1'b0;
      checks++;
      if (pixel_valid !== 1'b0 || overflow !== 1'b0 || pixel_count !== 16'd0) begin
         failures++;
         $display("FAIL midreset_state got=%b/%b/%0d exp=0/0/0", pixel_valid, overflow, pixel_count);
      end
      pixel_accept = 1'b1;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (pixel_valid) stale++;
      end
      checks++;
      if (stale != 0) begin failures++; $display("FAIL midreset_stale got=%0d exp=0", stale); end
      send(32'd1280, 32'd0, 32'd0);
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_out !== 8'd5) begin
         failures++; $display("FAIL midreset_fresh got=%b/%0d exp=1/5", pixel_valid, pixel_out);
      end
      step();
   endtask

   task automatic test_rounding();
      logic [7:0] exp_p;
      do_reset();
      pixel_accept = 1'b1;
      bias = 32'd0;
`ifdef ROUND_NEAREST_EN
      exp_p = 8'd1;
`else
      exp_p = 8'd0;
`endif
      send(32'd128, 32'd0, 32'd0);
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_out !== exp_p) begin
         failures++; $display("FAIL rounding got=%b/%0d exp=1/%0d", pixel_valid, pixel_out, exp_p);
      end
      step();
   endtask

   initial begin
      reset = 1'b1;
      R_dotproduct = '0; G_dotproduct = '0; B_dotproduct = '0; bias = '0;
      R_ready = 1'b0; G_ready = 1'b0; B_ready = 1'b0;
      pixel_accept = 1'b0;
      test_reset();
      test_single();
      test_relu();
      test_saturation();
      test_skew();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_rounding();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
